// File: rtl/pim_pkg.sv
// Shared opcode/state types and width helpers for the PIM multiply-accumulate CFU.
package pim_pkg;

    typedef enum logic [2:0] {
        OP_WRITE    = 3'd0,
        OP_READ     = 3'd1,
        OP_SET_ACT  = 3'd2,
        OP_MAC      = 3'd3,
        OP_READ_COL = 3'd4,
        OP_CLEAR    = 3'd5,
        OP_RSVD6    = 3'd6,
        OP_RSVD7    = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SUM  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam int DEF_ROWS   = 16;
    localparam int DEF_COLS   = 32;
    localparam int DEF_IBITS  = 4;
    localparam int DEF_DWIDTH = 32;

    // One ADC sample counts up to ROWS set bits; IBITS weighted samples cannot overflow acc.
    function automatic int adc_width(input int rows);
        return $clog2(rows + 1);
    endfunction

    function automatic int acc_width(input int rows, input int ibits);
        return $clog2(rows + 1) + ibits;
    endfunction

    localparam int DEF_ADC_W = adc_width(DEF_ROWS);
    localparam int DEF_ACC_W = acc_width(DEF_ROWS, DEF_IBITS);

endpackage

// File: rtl/pim_mac_cfu_if.sv
// CFU command/response bus; the master issues commands and collects responses.
interface pim_mac_cfu_if
    import pim_pkg::*;
#(
    parameter int DWIDTH = 32
) ();

    // Both channels are valid/ready: a beat transfers on a clock edge where valid && ready;
    // once raised, valid and its payload hold steady until that edge.
    logic              cmd_valid;
    logic              cmd_ready;
    logic [9:0]        cmd_payload_function_id;
    logic [31:0]       cmd_payload_inputs_0;
    logic [31:0]       cmd_payload_inputs_1;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_payload_response_ok;
    logic [DWIDTH-1:0] rsp_payload_outputs_0;
    state_e            dbg_state;

    modport master (
        output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
        output rsp_ready,
        input  cmd_ready, rsp_valid, rsp_payload_response_ok, rsp_payload_outputs_0, dbg_state
    );

    modport slave (
        input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
        input  rsp_ready,
        output cmd_ready, rsp_valid, rsp_payload_response_ok, rsp_payload_outputs_0, dbg_state
    );

endinterface

// File: rtl/pim_col_adc.sv
// One column's sense path: counts rows whose stored bit and read word line are both set.
module pim_col_adc
    import pim_pkg::*;
#(
    parameter int ROWS = 16
) (
    input  logic [ROWS-1:0]             i_col,
    input  logic [ROWS-1:0]             i_rwl,
    output logic [$clog2(ROWS+1)-1:0]   o_count
);

    localparam int ADC_W = adc_width(ROWS);

    always_comb begin
        o_count = '0;
        for (int j = 0; j < ROWS; j++) begin
            o_count = o_count + ADC_W'(i_col[j] & i_rwl[j]);
        end
    end

endmodule

// File: rtl/pim_mac_cfu.sv
// PIM multiply-accumulate CFU: a ROWS x COLS bit array with per-row activations
// applied bit-serially, one popcount ADC per column, and a summing response stage.
module pim_mac_cfu
    import pim_pkg::*;
#(
    parameter int ROWS   = 16,
    parameter int COLS   = 32,
    parameter int IBITS  = 4,
    parameter int DWIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    pim_mac_cfu_if.slave  cfu
);

    localparam int ADC_W  = adc_width(ROWS);
    localparam int ACC_W  = acc_width(ROWS, IBITS);
    localparam int K_W    = (IBITS > 1) ? $clog2(IBITS) : 1;
    localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CIDX_W = (COLS > 1) ? $clog2(COLS) : 1;

    state_e              r_state;
    state_e              w_next_state;
    logic [K_W-1:0]      r_k;
    logic [COLS-1:0]     r_mem [ROWS] = '{default: '0};
    logic [IBITS-1:0]    r_act [ROWS];
    logic [ACC_W-1:0]    r_acc [COLS];
    logic                r_rsp_ok;
    logic [DWIDTH-1:0]   r_rsp_data;

    op_e                 w_op;
    logic                w_accept;
    logic                w_cmd_ready;
    logic                w_rsp_valid;
    logic [RIDX_W-1:0]   w_row;
    logic [CIDX_W-1:0]   w_col;
    logic                w_row_ok;
    logic                w_col_ok;
    logic                w_cmd_ok;
    logic [DWIDTH-1:0]   w_cmd_data;
    logic [ROWS-1:0]     w_rwl;
    logic [ROWS-1:0]     w_col_bits [COLS];
    logic [ADC_W-1:0]    w_adc [COLS];
    logic [DWIDTH-1:0]   w_total;
    logic                w_unused_bits;

    assign w_op     = op_e'(cfu.cmd_payload_function_id[2:0]);
    assign w_row    = cfu.cmd_payload_inputs_0[RIDX_W-1:0];
    assign w_col    = cfu.cmd_payload_inputs_0[CIDX_W-1:0];
    assign w_row_ok = (cfu.cmd_payload_inputs_0 < 32'(ROWS));
    assign w_col_ok = (cfu.cmd_payload_inputs_0 < 32'(COLS));
    assign w_accept = cfu.cmd_valid && w_cmd_ready;
    assign w_unused_bits = ^{cfu.cmd_payload_function_id[9:3], cfu.cmd_payload_inputs_1};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cmd_ready  = 1'b0;
        w_rsp_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                if (cfu.cmd_valid) begin
                    w_next_state = (w_op == OP_MAC) ? ST_RUN : ST_RESP;
                end
            end
            ST_RUN: begin
                if (r_k == K_W'(IBITS - 1)) begin
                    w_next_state = ST_SUM;
                end
            end
            ST_SUM: begin
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                w_rsp_valid = 1'b1;
                if (cfu.rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Immediate response of every non-MAC opcode; illegal indices or opcodes yield ok=0, data=0.
    always_comb begin
        w_cmd_ok   = 1'b0;
        w_cmd_data = '0;
        case (w_op)
            OP_WRITE: begin
                if (w_row_ok) begin
                    w_cmd_ok   = 1'b1;
                    w_cmd_data = DWIDTH'(cfu.cmd_payload_inputs_1[COLS-1:0]);
                end
            end
            OP_READ: begin
                if (w_row_ok) begin
                    w_cmd_ok   = 1'b1;
                    w_cmd_data = DWIDTH'(r_mem[w_row]);
                end
            end
            OP_SET_ACT: begin
                if (w_row_ok) begin
                    w_cmd_ok   = 1'b1;
                    w_cmd_data = DWIDTH'(cfu.cmd_payload_inputs_1[IBITS-1:0]);
                end
            end
            OP_READ_COL: begin
                if (w_col_ok) begin
                    w_cmd_ok   = 1'b1;
                    w_cmd_data = DWIDTH'(r_acc[w_col]);
                end
            end
            OP_MAC, OP_CLEAR: begin
                w_cmd_ok = 1'b1;
            end
            default: begin
                w_cmd_ok = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_rwl      = '0;
        w_col_bits = '{default: '0};
        for (int j = 0; j < ROWS; j++) begin
            w_rwl[j] = r_act[j][r_k];
            for (int i = 0; i < COLS; i++) begin
                w_col_bits[i][j] = r_mem[j][i];
            end
        end
    end

    for (genvar gi = 0; gi < COLS; gi++) begin : g_adc
        pim_col_adc #(.ROWS(ROWS)) u_adc (
            .i_col   (w_col_bits[gi]),
            .i_rwl   (w_rwl),
            .o_count (w_adc[gi])
        );
    end

    always_comb begin
        w_total = '0;
        for (int i = 0; i < COLS; i++) begin
            w_total = w_total + DWIDTH'(r_acc[i]);
        end
    end

    // Control, activation, accumulator and response registers; all cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_k        <= '0;
            r_rsp_ok   <= 1'b0;
            r_rsp_data <= '0;
            for (int j = 0; j < ROWS; j++) begin
                r_act[j] <= '0;
            end
            for (int i = 0; i < COLS; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_k        <= '0;
                r_rsp_ok   <= w_cmd_ok;
                r_rsp_data <= w_cmd_data;
                if (w_op == OP_SET_ACT && w_row_ok) begin
                    r_act[w_row] <= cfu.cmd_payload_inputs_1[IBITS-1:0];
                end
                if (w_op == OP_CLEAR) begin
                    for (int j = 0; j < ROWS; j++) begin
                        r_act[j] <= '0;
                    end
                end
                if (w_op == OP_MAC) begin
                    for (int i = 0; i < COLS; i++) begin
                        r_acc[i] <= '0;
                    end
                end
            end
            if (r_state == ST_RUN) begin
                r_k <= r_k + K_W'(1);
                for (int i = 0; i < COLS; i++) begin
                    r_acc[i] <= r_acc[i] + (ACC_W'(w_adc[i]) << r_k);
                end
            end
            if (r_state == ST_SUM) begin
                r_rsp_ok   <= 1'b1;
                r_rsp_data <= w_total;
            end
        end
    end

    // The array is never reset so an aborted command cannot disturb stored contents.
    always_ff @(posedge clk) begin
        if (reset && w_accept) begin
            if (w_op == OP_WRITE && w_row_ok) begin
                r_mem[w_row] <= cfu.cmd_payload_inputs_1[COLS-1:0];
            end else if (w_op == OP_CLEAR) begin
                for (int j = 0; j < ROWS; j++) begin
                    r_mem[j] <= '0;
                end
            end
        end
    end

    assign cfu.cmd_ready               = w_cmd_ready;
    assign cfu.rsp_valid               = w_rsp_valid;
    assign cfu.rsp_payload_response_ok = r_rsp_ok;
    assign cfu.rsp_payload_outputs_0   = r_rsp_data;
    assign cfu.dbg_state               = r_state;

endmodule

// File: tb/tb_pim_mac_cfu.sv
// Directed bench for pim_mac_cfu: queued expected responses checked by an independent monitor.
module tb_pim_mac_cfu;
    import pim_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pim_mac_cfu_if #(.DWIDTH(32)) cfu_if ();

    pim_mac_cfu #(.ROWS(16), .COLS(32), .IBITS(4), .DWIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .cfu   (cfu_if)
    );

    logic [32:0] exp_q[$];
    logic [31:0] model_mem [16];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Monitor: every response handshake pops one expected {ok, data} entry.
    always @(negedge clk) begin
        if (reset === 1'b1 && cfu_if.rsp_valid === 1'b1 && cfu_if.rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_rsp: got ok=%0b data=0x%0h, expected no response",
                         cfu_if.rsp_payload_response_ok, cfu_if.rsp_payload_outputs_0);
            end else begin
                check("rsp", {31'b0, cfu_if.rsp_payload_response_ok, cfu_if.rsp_payload_outputs_0},
                      {31'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Drivers are entered and left 1 time unit after a rising edge.
    task automatic send(input logic [2:0] op, input logic [31:0] in0, input logic [31:0] in1);
        int budget = 0;
        cfu_if.cmd_payload_function_id = {7'b0, op};
        cfu_if.cmd_payload_inputs_0    = in0;
        cfu_if.cmd_payload_inputs_1    = in1;
        cfu_if.cmd_valid               = 1'b1;
        while (cfu_if.cmd_ready !== 1'b1 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 50) begin
            n_checks++;
            $display("FAIL accept_timeout: cmd_ready=0, expected 1");
            cfu_if.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cfu_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input int exp_lat);
        int lat = 1;
        while (cfu_if.rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] in0,
                         input logic [31:0] in1, input logic ok, input logic [31:0] data,
                         input int lat);
        exp_q.push_back({ok, data});
        if (op == 3'(OP_WRITE) && in0 < 16) model_mem[in0[3:0]] = in1;
        if (op == 3'(OP_CLEAR)) for (int j = 0; j < 16; j++) model_mem[j] = '0;
        send(op, in0, in1);
        wait_rsp(name, lat);
        @(posedge clk); #1;
    endtask

    initial begin
        bit seen_rsp;
        for (int j = 0; j < 16; j++) model_mem[j] = '0;
        reset                          = 1'b0;
        cfu_if.cmd_valid               = 1'b0;
        cfu_if.cmd_payload_function_id = '0;
        cfu_if.cmd_payload_inputs_0    = '0;
        cfu_if.cmd_payload_inputs_1    = '0;
        cfu_if.rsp_ready               = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 64'(cfu_if.dbg_state), 64'(ST_IDLE));
        check("reset_rsp_valid", 64'(cfu_if.rsp_valid), 64'd0);
        check("reset_cmd_ready", 64'(cfu_if.cmd_ready), 64'd1);
        check("reset_outputs", 64'(cfu_if.rsp_payload_outputs_0), 64'd0);
        check("reset_ok", 64'(cfu_if.rsp_payload_response_ok), 64'd0);
        reset = 1'b1;

        // Single active bit, activation 0b0101 -> 1 + 4.
        do_op("wr_r0", OP_WRITE, 0, 32'h1, 1'b1, 32'h1, 1);
        do_op("act_r0", OP_SET_ACT, 0, 32'h5, 1'b1, 32'h5, 1);
        do_op("mac_a", OP_MAC, 0, 0, 1'b1, 32'd5, 6);
        do_op("rdcol0_a", OP_READ_COL, 0, 0, 1'b1, 32'd5, 1);

        // Two full rows at activation 15: every column accumulates 2*15.
        do_op("wr_r0_ff", OP_WRITE, 0, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1);
        do_op("wr_r1_ff", OP_WRITE, 1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1);
        do_op("act_r0_f", OP_SET_ACT, 0, 32'hF, 1'b1, 32'hF, 1);
        do_op("act_r1_f", OP_SET_ACT, 1, 32'hFF, 1'b1, 32'hF, 1);
        do_op("mac_b", OP_MAC, 0, 0, 1'b1, 32'd960, 6);
        do_op("rdcol3", OP_READ_COL, 3, 0, 1'b1, 32'd30, 1);
        do_op("rdcol31", OP_READ_COL, 31, 0, 1'b1, 32'd30, 1);
        do_op("rdcol32", OP_READ_COL, 32, 0, 1'b0, 32'd0, 1);
        do_op("rd_r1", OP_READ, 1, 0, 1'b1, 32'hFFFF_FFFF, 1);

        // Response back-pressure: held stable for 3 cycles, no new command accepted.
        cfu_if.rsp_ready = 1'b0;
        exp_q.push_back({1'b1, 32'h0001_2345});
        model_mem[2] = 32'h0001_2345;
        send(OP_WRITE, 2, 32'h0001_2345);
        wait_rsp("hold", 1);
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", 64'(cfu_if.rsp_valid), 64'd1);
            check("hold_data", 64'(cfu_if.rsp_payload_outputs_0), 64'h0001_2345);
            check("hold_cmd_ready", 64'(cfu_if.cmd_ready), 64'd0);
            @(posedge clk); #1;
        end
        cfu_if.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_done_valid", 64'(cfu_if.rsp_valid), 64'd0);
        check("hold_done_ready", 64'(cfu_if.cmd_ready), 64'd1);

        // Illegal rows and opcodes have no side effect.
        do_op("wr_r16", OP_WRITE, 16, 32'hAA, 1'b0, 32'd0, 1);
        do_op("wr_big", OP_WRITE, 32'h0001_0000, 32'hBB, 1'b0, 32'd0, 1);
        do_op("act_r16", OP_SET_ACT, 16, 32'h3, 1'b0, 32'd0, 1);
        for (int r = 0; r < 16; r++) do_op("rd_all", OP_READ, r, 0, 1'b1, model_mem[r], 1);
        do_op("op7", 3'd7, 0, 32'h1234, 1'b0, 32'd0, 1);
        do_op("op6", 3'd6, 1, 32'h1234, 1'b0, 32'd0, 1);
        do_op("rd_r0_after_bad", OP_READ, 0, 0, 1'b1, 32'hFFFF_FFFF, 1);

        // Reset during RUN aborts the MAC with no response.
        send(OP_MAC, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_state", 64'(cfu_if.dbg_state), 64'(ST_IDLE));
        check("abort_rsp_valid", 64'(cfu_if.rsp_valid), 64'd0);
        reset = 1'b1;
        seen_rsp = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (cfu_if.rsp_valid === 1'b1) seen_rsp = 1'b1;
        end
        check("abort_no_rsp", 64'(seen_rsp), 64'd0);
        do_op("rd_r0_post_rst", OP_READ, 0, 0, 1'b1, 32'hFFFF_FFFF, 1);
        do_op("rd_r2_post_rst", OP_READ, 2, 0, 1'b1, 32'h0001_2345, 1);
        do_op("rdcol3_post_rst", OP_READ_COL, 3, 0, 1'b1, 32'd0, 1);
        do_op("mac_no_act", OP_MAC, 0, 0, 1'b1, 32'd0, 6);

        // CLEAR wipes both array and activations.
        do_op("act_r0_f2", OP_SET_ACT, 0, 32'hF, 1'b1, 32'hF, 1);
        do_op("clear", OP_CLEAR, 0, 0, 1'b1, 32'd0, 1);
        do_op("mac_clr", OP_MAC, 0, 0, 1'b1, 32'd0, 6);
        do_op("act_r0_f3", OP_SET_ACT, 0, 32'hF, 1'b1, 32'hF, 1);
        do_op("mac_clr_mem", OP_MAC, 0, 0, 1'b1, 32'd0, 6);
        do_op("rd_r0_clr", OP_READ, 0, 0, 1'b1, 32'd0, 1);
        do_op("rd_r2_clr", OP_READ, 2, 0, 1'b1, 32'd0, 1);

        // A distinct pattern after clear: row 3 = 0xF0 at act 3, row 5 = 0x1 at act 2.
        do_op("wr_r3", OP_WRITE, 3, 32'h0000_00F0, 1'b1, 32'h0000_00F0, 1);
        do_op("wr_r5", OP_WRITE, 5, 32'h0000_0001, 1'b1, 32'h0000_0001, 1);
        do_op("act_r3", OP_SET_ACT, 3, 32'h3, 1'b1, 32'h3, 1);
        do_op("act_r5", OP_SET_ACT, 5, 32'h2, 1'b1, 32'h2, 1);
        do_op("act_r0_0", OP_SET_ACT, 0, 32'h0, 1'b1, 32'h0, 1);
        do_op("mac_c", OP_MAC, 0, 0, 1'b1, 32'd14, 6);
        do_op("rdcol4_c", OP_READ_COL, 4, 0, 1'b1, 32'd3, 1);
        do_op("rdcol0_c", OP_READ_COL, 0, 0, 1'b1, 32'd2, 1);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pim_mac_cfu.md
PIM_MAC_CFU -- requirements
Module: pim_mac_cfu

Interface
REQ-001 Parameters SHALL be: ROWS, 16, number of PIM memory rows; COLS, 32, bits per row (columns, max 32); IBITS, 4, activation bits per row, applied bit-serially; DWIDTH, 32, response data width.
REQ-002 Ports SHALL be: clk  in  1  single clock; reset  in  1  synchronous, active-low reset.
REQ-003 Ports SHALL be: cmd_valid  in  1; cmd_ready  out  1; cmd_payload_function_id  in  10  (opcode in [2:0], rest ignored); cmd_payload_inputs_0  in  32  row or column index; cmd_payload_inputs_1  in  32  data.
REQ-004 Ports SHALL be: rsp_valid  out  1; rsp_ready  in  1; rsp_payload_response_ok  out  1  1 = legal command; rsp_payload_outputs_0  out  DWIDTH  result.

Function
REQ-005 Opcodes SHALL be: 0 WRITE, mem[inputs_0] <= inputs_1[COLS-1:0], response = written data; 1 READ, response = mem[inputs_0] zero-extended; 2 SET_ACT, act[inputs_0] <= inputs_1[IBITS-1:0], response = the stored value.
REQ-006 Further opcodes SHALL be: 3 MAC, bit-serial multiply-accumulate, response = total; 4 READ_COL, response = acc[inputs_0] from the last MAC; 5 CLEAR, all mem and act set to 0 in one cycle, response 0.
REQ-007 Opcodes 6 and 7 SHALL respond with response_ok=0 and output 0 and SHALL have no side effect.
REQ-008 A row index >= ROWS (ops 0,1,2) or column index >= COLS (op 4) SHALL respond with response_ok=0 and output 0, with no write.
REQ-009 FSM states SHALL be IDLE, RUN, SUM and RESP; cmd_ready SHALL be 1 only in IDLE; a command is accepted on the cycle where cmd_valid && cmd_ready.
REQ-010 Non-MAC ops: IDLE->RESP on accept, with side effects committed on the accept edge; rsp_valid SHALL rise 1 cycle after accept.
REQ-011 MAC: IDLE->RUN on accept with bit counter k=0 and acc[] cleared; RUN runs for IBITS cycles, then RUN->SUM->RESP; rsp_valid SHALL rise IBITS+2 cycles after accept.
REQ-012 In RUN cycle k, rwl[j]=act[j][k]; adc[i]=popcount over j of (mem[j][i] & rwl[j]); acc[i] += adc[i] << k.
REQ-013 Widths SHALL be: adc = clog2(ROWS+1) bits; acc = adc width + IBITS bits, with no overflow possible.
REQ-014 In SUM, total = sum of acc[0..COLS-1], computed modulo 2^DWIDTH and registered into the response register.
REQ-015 In RESP, rsp_valid, outputs_0 and response_ok SHALL be held stable until rsp_ready=1; then RESP->IDLE on the same edge; rsp_ready is ignored outside RESP.
REQ-016 With rsp_ready held at 1, back-to-back commands SHALL be accepted at most every 2 cycles (non-MAC ops).
REQ-017 mem and act SHALL NOT be modified during RUN or SUM; acc[] SHALL persist until the next accepted MAC.

Reset
REQ-018 While reset=0 at a clk edge: state=IDLE; rsp_valid=0; cmd_ready=1 from the following cycle; outputs_0=0; response_ok=0; k=0; acc[] cleared; act[] cleared.
REQ-019 mem SHALL NOT be reset; mem SHALL initialise to 0 in simulation only, and is cleared at runtime via CLEAR.
REQ-020 Reset asserted mid-MAC or mid-RESP SHALL abort the operation with no response and SHALL leave mem unchanged.

Structure
REQ-021 Shared package pim_pkg SHALL hold the opcode enumeration, the FSM state type and the width helper constants (adc and acc widths).
REQ-022 Per-column popcount SHALL be one sub-module, pim_col_adc (ROWS-bit AND-masked popcount), instantiated COLS times.

Verification
REQ-023 Defaults; WRITE row0=0x1, SET_ACT row0=0x5, MAC -> outputs_0=5, ok=1, rsp_valid exactly 6 cycles after accept.
REQ-024 WRITE rows 0 and 1 = 0xFFFFFFFF, SET_ACT rows 0 and 1 = 0xF, MAC -> 960; READ_COL 3 -> 30; READ_COL 32 -> ok=0, output 0.
REQ-025 Hold rsp_ready=0 for 3 cycles after rsp_valid rises -> outputs_0 stable, cmd_ready=0 throughout; completes on the cycle rsp_ready=1.
REQ-026 WRITE row 16 = 0xAA -> ok=0; READ rows 0..15 unchanged; opcode 7 -> ok=0, output 0.
REQ-027 reset=0 during RUN cycle 2 -> next cycle state IDLE, rsp_valid=0; READ row0 still returns its pre-reset value; MAC with act cleared -> 0.
REQ-028 CLEAR, then MAC -> 0; READ of any row -> 0.
